// File: rtl/camera_ctrl_sequencer.sv
// camera_ctrl_sequencer
//   Walks a table of 16-bit words held in a command RAM and turns it into
//   camera register writes. Each word is either a terminator (0xFFFF), a
//   delay (0xFEnn, nn*DELAY_UNIT clk cycles) or a register write
//   (reg=[15:8], data=[7:0]). When the table ends, or the last table word
//   has been consumed, a status word is written back to RAM word STATUS_ADDR:
//   {1'b1, overflow, 8'b0, count}.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   start             one-cycle request to run the table (honoured in IDLE only)
//   mem_*             RAM port 2: 1-cycle read latency, write used only for status
//   cmd_valid/ready   register-write handshake to the serializer
//   cmd_reg/cmd_data  register address/value, stable while cmd_valid=1
//   busy, done        run in progress / one-cycle completion pulse
//   count             commands issued in the current or last run

module camera_ctrl_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int STATUS_ADDR = 63,
  parameter int DELAY_UNIT  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [15:0]       mem_writedata,
  output logic [1:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [15:0]       mem_readdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_reg,
  output logic [7:0]        cmd_data,
  output logic              busy,
  output logic              done,
  output logic [5:0]        count
);

  // Wide enough for the longest delay, 255*DELAY_UNIT-1.
  localparam int CNT_W = $clog2(255 * DELAY_UNIT + 1);

  localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(STATUS_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(STATUS_ADDR - 1);
  localparam logic [CNT_W-1:0]  UNIT_C   = CNT_W'(DELAY_UNIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_ISSUE,
    ST_DELAY,
    ST_STATUS_WR,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [5:0]         count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        entry_q, entry_d;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d;
  logic               advance;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      entry_q    <= '0;
      dcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      entry_q    <= entry_d;
      dcnt_q     <= dcnt_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    ptr_d          = ptr_q;
    count_d        = count_q;
    overflow_d     = overflow_q;
    entry_d        = entry_q;
    dcnt_d         = dcnt_q;
    advance        = 1'b0;
    mem_address    = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    mem_byteenable = 2'b00;
    cmd_valid      = 1'b0;
    cmd_reg        = '0;
    cmd_data       = '0;
    done           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_address    = ptr_q;
        mem_chipselect = 1'b1;
        mem_byteenable = 2'b11;
        state_d        = ST_CAPTURE;
      end

      // Read data for the FETCH address is valid in this cycle; decode it
      // directly so a zero-length delay costs no extra cycle.
      ST_CAPTURE: begin
        entry_d = mem_readdata;
        if (mem_readdata == 16'hFFFF) begin
          state_d = ST_STATUS_WR;
        end else if (mem_readdata[15:8] == 8'hFE) begin
          if (mem_readdata[7:0] == 8'h00) begin
            advance = 1'b1;
          end else begin
            // Counter runs down to 0 inclusive: nn*DELAY_UNIT cycles total.
            dcnt_d  = CNT_W'(mem_readdata[7:0]) * UNIT_C - CNT_W'(1);
            state_d = ST_DELAY;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cmd_valid = 1'b1;
        cmd_reg   = entry_q[15:8];
        cmd_data  = entry_q[7:0];
        if (cmd_ready) begin
          count_d = count_q + 6'd1;
          advance = 1'b1;
        end
      end

      ST_DELAY: begin
        if (dcnt_q == '0) begin
          advance = 1'b1;
        end else begin
          dcnt_d = dcnt_q - CNT_W'(1);
        end
      end

      ST_STATUS_WR: begin
        mem_address    = STATUS_A;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_byteenable = 2'b11;
        mem_writedata  = {1'b1, overflow_q, 8'b0, count_q};
        state_d        = ST_DONE;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Moving past a consumed entry; the last table word ends the run with
    // the overflow flag set so the status slot itself is never fetched.
    if (advance) begin
      if (ptr_q == LAST_PTR) begin
        overflow_d = 1'b1;
        state_d    = ST_STATUS_WR;
      end else begin
        ptr_d   = ptr_q + ADDR_W'(1);
        state_d = ST_FETCH;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign count     = count_q;
  assign mem_clken = 1'b1;

endmodule

// File: tb/tb_camera_ctrl_sequencer.sv
// Testbench for camera_ctrl_sequencer: a table of whole-run vectors
// (RAM contents, handshake stall, expected commands/status/timing) plus
// hand-written sequences for start-while-busy and mid-run reset.

module tb_camera_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [15:0] mem_writedata;
  logic [1:0]  mem_byteenable;
  logic        mem_clken;
  logic [15:0] mem_readdata = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [7:0]  cmd_reg;
  logic [7:0]  cmd_data;
  logic        busy;
  logic        done;
  logic [5:0]  count;

  camera_ctrl_sequencer #(
    .ADDR_W     (6),
    .STATUS_ADDR(63),
    .DELAY_UNIT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mem_address   (mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_write     (mem_write),
    .mem_writedata (mem_writedata),
    .mem_byteenable(mem_byteenable),
    .mem_clken     (mem_clken),
    .mem_readdata  (mem_readdata),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_reg       (cmd_reg),
    .cmd_data      (cmd_data),
    .busy          (busy),
    .done          (done),
    .count         (count)
  );

  always #5 clk = ~clk;

  // Command RAM model: 1-cycle read latency.
  logic [15:0] ram [64];
  always @(posedge clk) begin
    if (mem_chipselect && !mem_write) mem_readdata <= ram[mem_address];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor state, all sampled on the falling edge.
  int          busy_cyc, done_cnt, valid_cyc, unstable, wr_cnt, wr_bad, rd63, be_bad;
  int          stall_cnt, stall_n = 0, block_after = 1000;
  logic [15:0] last_wr, prev_cmd;
  bit          have_prev;
  logic [15:0] cmd_log [$];

  task automatic clear_mon();
    busy_cyc = 0; done_cnt = 0; valid_cyc = 0; unstable = 0;
    wr_cnt = 0; wr_bad = 0; rd63 = 0; be_bad = 0;
    stall_cnt = 0; have_prev = 0; last_wr = '0;
    cmd_log.delete();
  endtask

  // Also drives cmd_ready: held low for stall_n valid cycles per command,
  // held low forever once block_after commands were accepted, and high
  // whenever cmd_valid is low.
  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (mem_chipselect) begin
      if (mem_byteenable != 2'b11) be_bad++;
      if (mem_write) begin
        wr_cnt++;
        if (mem_address != 6'd63) wr_bad++;
        last_wr = mem_writedata;
      end else if (mem_address == 6'd63) begin
        rd63++;
      end
    end
    if (cmd_valid) begin
      valid_cyc++;
      if (have_prev && {cmd_reg, cmd_data} != prev_cmd) unstable++;
      prev_cmd  = {cmd_reg, cmd_data};
      have_prev = 1'b1;
      if (stall_cnt >= stall_n && cmd_log.size() < block_after) begin
        cmd_ready = 1'b1;
        cmd_log.push_back(prev_cmd);
        stall_cnt = 0;
        have_prev = 1'b0;
      end else begin
        cmd_ready = 1'b0;
        stall_cnt++;
      end
    end else begin
      cmd_ready = 1'b1;
    end
  end

  typedef struct {
    string       name;
    logic [15:0] w0, w1, w2, fill;
    int          stall;
    int          exp_cmds;
    logic [15:0] exp_c0, exp_c1, exp_status;
    int          exp_busy, exp_valid;
  } vec_t;

  vec_t vecs [8];

  task automatic load_ram(input logic [15:0] w0, w1, w2, w3, fill);
    for (int i = 0; i < 64; i++) ram[i] = fill;
    ram[0] = w0; ram[1] = w1; ram[2] = w2; ram[3] = w3;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit seen;
    @(negedge clk);
    load_ram(v.w0, v.w1, v.w2, v.fill, v.fill);
    clear_mon();
    stall_n = v.stall;
    pulse_start();
    wait_done(2000, seen);
    @(negedge clk);
    check({v.name, "/done_seen"}, 32'(seen), 1);
    check({v.name, "/done_pulses"}, done_cnt, 1);
    check({v.name, "/count"}, 32'(count), v.exp_cmds);
    check({v.name, "/n_cmds"}, cmd_log.size(), v.exp_cmds);
    if (v.exp_cmds >= 1 && cmd_log.size() >= 1) check({v.name, "/cmd0"}, cmd_log[0], v.exp_c0);
    if (v.exp_cmds >= 2 && cmd_log.size() >= 2) check({v.name, "/cmd1"}, cmd_log[1], v.exp_c1);
    check({v.name, "/status_writes"}, wr_cnt, 1);
    check({v.name, "/bad_wr_addr"}, wr_bad, 0);
    check({v.name, "/status_word"}, last_wr, v.exp_status);
    check({v.name, "/busy_cycles"}, busy_cyc, v.exp_busy);
    check({v.name, "/valid_cycles"}, valid_cyc, v.exp_valid);
    check({v.name, "/cmd_unstable"}, unstable, 0);
    check({v.name, "/read_addr63"}, rd63, 0);
    check({v.name, "/byteenable"}, be_bad, 0);
    check({v.name, "/busy_after"}, 32'(busy), 0);
  endtask

  initial begin
    bit seen;
    bit found;

    // name, w0, w1, w2, fill, stall, cmds, c0, c1, status, busy cycles, valid cycles
    vecs[0] = '{"two_cmds",  16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 0,  2, 16'h1280, 16'h1101, 16'h8002, 10,  2};
    vecs[1] = '{"stall10",   16'h3A04, 16'hFFFF, 16'hFFFF, 16'hFFFF, 10, 1, 16'h3A04, 16'h0000, 16'h8001, 17, 11};
    vecs[2] = '{"delay3",    16'hFE03, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0,  0, 16'h0000, 16'h0000, 16'h8000, 18,  0};
    vecs[3] = '{"delay0",    16'hFE00, 16'h1234, 16'hFFFF, 16'hFFFF, 0,  1, 16'h1234, 16'h0000, 16'h8001,  9,  1};
    vecs[4] = '{"delay1",    16'hFE01, 16'h5566, 16'hFFFF, 16'hFFFF, 0,  1, 16'h5566, 16'h0000, 16'h8001, 13,  1};
    vecs[5] = '{"stall2",    16'hAB12, 16'hCD34, 16'hFFFF, 16'hFFFF, 2,  2, 16'hAB12, 16'hCD34, 16'h8002, 14,  6};
    vecs[6] = '{"no_term",   16'h0101, 16'h0101, 16'h0101, 16'h0101, 0, 63, 16'h0101, 16'h0101, 16'hC03F, 191, 63};
    vecs[7] = '{"term_only", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0,  0, 16'h0000, 16'h0000, 16'h8000,  4,  0};

    // Reset state.
    reset = 1'b1;
    start = 1'b0;
    load_ram(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/cmd_valid", 32'(cmd_valid), 0);
    check("rst/busy", 32'(busy), 0);
    check("rst/done", 32'(done), 0);
    check("rst/chipselect", 32'(mem_chipselect), 0);
    check("rst/write", 32'(mem_write), 0);
    check("rst/count", 32'(count), 0);
    check("rst/writedata", 32'(mem_writedata), 0);
    check("rst/cmd_reg_data", 32'({cmd_reg, cmd_data}), 0);
    check("rst/clken", 32'(mem_clken), 1);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);
    stall_n = 0;

    // Start pulses while busy are ignored: one run, one done pulse.
    @(negedge clk);
    load_ram(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    clear_mon();
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done(200, seen);
    repeat (20) @(negedge clk);
    check("busy_start/done_seen", 32'(seen), 1);
    check("busy_start/done_pulses", done_cnt, 1);
    check("busy_start/n_cmds", cmd_log.size(), 2);
    check("busy_start/status_writes", wr_cnt, 1);
    check("busy_start/busy_cycles", busy_cyc, 10);

    // Reset while issuing entry 2, with the serializer stalling.
    load_ram(16'h1111, 16'h2222, 16'h3333, 16'hFFFF, 16'hFFFF);
    clear_mon();
    block_after = 2;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_reg == 8'h33) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_issue/reached_entry2", 32'(found), 1);
    repeat (3) @(negedge clk);
    check("rst_issue/valid_before", 32'(cmd_valid), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_issue/cmd_valid", 32'(cmd_valid), 0);
    check("rst_issue/busy", 32'(busy), 0);
    check("rst_issue/count", 32'(count), 0);
    check("rst_issue/chipselect", 32'(mem_chipselect), 0);
    @(negedge clk);
    reset = 1'b0;
    block_after = 1000;
    repeat (10) @(negedge clk);
    check("rst_issue/no_status_write", wr_cnt, 0);
    check("rst_issue/no_done", done_cnt, 0);
    clear_mon();
    pulse_start();
    wait_done(200, seen);
    @(negedge clk);
    check("rerun/done_seen", 32'(seen), 1);
    check("rerun/n_cmds", cmd_log.size(), 3);
    if (cmd_log.size() >= 1) check("rerun/cmd0", cmd_log[0], 16'h1111);
    check("rerun/status_word", last_wr, 16'h8003);
    check("rerun/done_pulses", done_cnt, 1);

    // Reset during a long delay aborts with no status write.
    load_ram(16'hFE10, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    clear_mon();
    pulse_start();
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_delay/busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    check("rst_delay/no_status_write", wr_cnt, 0);
    check("rst_delay/no_done", done_cnt, 0);
    check("rst_delay/busy_after", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
